// File: rtl/fifo_serializer.sv
// fifo_serializer: reads 16-bit words from an external FIFO and sends each one as a
// frame of one start bit, 16 data bits (LSB first) and one stop bit, DIV clocks per bit.
module fifo_serializer #(
  parameter int unsigned DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        EMPTY,
  input  logic        VALID,
  input  logic [15:0] DIN,
  output logic        RD,
  output logic        SOUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  localparam logic [7:0] BAUD_LAST = 8'(DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  baud_q, baud_d;
  logic        rd_q, rd_d;
  logic        sout_q, sout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        baud_last_s;

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Next-state, datapath and counter updates
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (EN && !EMPTY) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (VALID) begin
          shift_d = DIN;
          bit_d   = 4'd0;
          baud_d  = 8'd0;
          state_d = S_START;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_d  = 8'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + 8'd1;
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d  = 8'd0;
          shift_d = {1'b0, shift_q[15:1]};
          if (bit_q == 4'd15) begin
            bit_d   = 4'd0;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d  = baud_q + 8'd1;
        end
      end
      S_STOP: begin
        if (baud_last_s) begin
          baud_d  = 8'd0;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          baud_d  = baud_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 8'd0;
        bit_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they come straight out of flops
  always_comb begin
    rd_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      S_START: sout_d = 1'b0;
      S_DATA:  sout_d = shift_d[0];
      default: sout_d = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      shift_q <= 16'h0000;
      bit_q   <= 4'd0;
      baud_q  <= 8'd0;
      rd_q    <= 1'b0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      rd_q    <= rd_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RD   = rd_q;
  assign SOUT = sout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: a frame-level expected-waveform model plus a FIFO stub,
// compared against the DUT on every cycle, with hand-computed checks on top.
module tb_fifo_serializer;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        EMPTY = 1'b1;
  logic        VALID = 1'b0;
  logic [15:0] DIN = 16'h0000;
  logic        RD, SOUT, BUSY, DONE, ERR;
  logic [7:0]  CNT;

  fifo_serializer #(.DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .VALID(VALID), .DIN(DIN),
    .RD(RD), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rd;
    logic sout;
    logic busy;
    logic done;
    logic set_err;
    logic inc_cnt;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] fifo[$];
  logic        lie = 1'b0;
  logic        prev_rd = 1'b0;
  logic        exp_err = 1'b0;
  logic [7:0]  exp_cnt = 8'd0;
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          rd_pulses = 0;
  int          done_pulses = 0;
  logic        rec = 1'b0;
  logic        rec_q[$];
  int          first_zero = -1;
  int          done_at = -1;
  logic        gap_pend = 1'b0;
  int          done_cyc = 0;
  int          last_gap = -1;

  function automatic exp_t mk(logic rd, logic so, logic bz, logic dn, logic se, logic ic);
    exp_t e;
    e.rd = rd; e.sout = so; e.busy = bz; e.done = dn; e.set_err = se; e.inc_cnt = ic;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
    end
  endtask

  // Expected waveform of one transaction, started from the cycle after the request decision
  task automatic build_frame();
    logic [15:0] w;
    expq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    expq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    if (fifo.size() > 0) begin
      w = fifo[0];
      for (int k = 0; k < DIV; k++) expq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int b = 0; b < 16; b++)
        for (int k = 0; k < DIV; k++) expq.push_back(mk(1'b0, w[b], 1'b1, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < DIV; k++)
        expq.push_back(mk(1'b0, 1'b1, 1'b1, (k == DIV - 1), 1'b0, 1'b0));
      expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  always @(posedge CLK) begin
    if (RST && expq.size() == 0 && EN && !EMPTY) build_frame();
  end

  task automatic compare();
    exp_t e;
    e = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (expq.size() > 0) e = expq.pop_front();
    if (e.set_err) exp_err = 1'b1;
    if (e.inc_cnt) exp_cnt = exp_cnt + 8'd1;
    chk("rd", RD, e.rd);
    chk("sout", SOUT, e.sout);
    chk("busy", BUSY, e.busy);
    chk("done", DONE, e.done);
    chk("err", ERR, exp_err);
    chk("cnt", CNT, exp_cnt);
    if (RD === 1'b1) rd_pulses++;
    if (DONE === 1'b1) done_pulses++;
    if (rec && BUSY === 1'b1) rec_q.push_back(SOUT);
    if (rec && SOUT === 1'b0 && first_zero < 0) first_zero = cyc_n;
    if (rec && DONE === 1'b1) done_at = cyc_n;
    if (DONE === 1'b1) begin
      gap_pend = 1'b1;
      done_cyc = cyc_n;
    end else if (gap_pend && SOUT === 1'b0) begin
      last_gap = cyc_n - done_cyc - 1;
      gap_pend = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    cyc_n++;
    compare();
    if (prev_rd && fifo.size() > 0) begin
      VALID = 1'b1;
      DIN = fifo.pop_front();
    end else begin
      VALID = 1'b0;
      DIN = 16'h0000;
    end
    prev_rd = RD;
    EMPTY = !(lie || fifo.size() > 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while ((expq.size() > 0 || fifo.size() > 0) && n < budget);
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required<%0d", n, budget);
    end
  endtask

  task automatic wait_rd(input int budget);
    int r0;
    r0 = rd_pulses;
    for (int i = 0; i < budget && rd_pulses == r0; i++) cyc();
    chk("rd_wait", rd_pulses - r0, 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk("rst_rd", RD, 1'b0);
    chk("rst_sout", SOUT, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_cnt", CNT, 8'd0);
    expq.delete();
    exp_err = 1'b0;
    exp_cnt = 8'd0;
    prev_rd = 1'b0;
    VALID = 1'b0;
    gap_pend = 1'b0;
    cyc();
    RST = 1'b1;
  endtask

  logic [0:17] pat;
  int r0, d0;

  initial begin
    #1 RST = 1'b0;
    repeat (3) cyc();
    chk("init_sout", SOUT, 1'b1);
    chk("init_cnt", CNT, 8'd0);
    RST = 1'b1;
    repeat (2) cyc();

    // Single word: start, LSB-first data, stop
    EN = 1'b1;
    rec = 1'b1;
    r0 = rd_pulses; d0 = done_pulses;
    fifo.push_back(16'hA5C3);
    drain(200);
    rec = 1'b0;
    pat = 18'b011000011101001011;
    chk("a5c3_len", rec_q.size(), 2 + 18 * DIV);
    if (rec_q.size() >= 2 + 18 * DIV)
      for (int k = 0; k < 18; k++)
        chk($sformatf("a5c3_bit%0d", k), rec_q[2 + DIV * k + 1], pat[k]);
    chk("frame_len", done_at - first_zero + 1, 18 * DIV);
    chk("a5c3_rd", rd_pulses - r0, 1);
    chk("a5c3_done", done_pulses - d0, 1);
    chk("a5c3_cnt", CNT, 8'd1);

    // Back-to-back frames
    r0 = rd_pulses;
    fifo.push_back(16'h0001);
    fifo.push_back(16'h8000);
    drain(400);
    chk("b2b_gap", last_gap, 3);
    chk("b2b_rd", rd_pulses - r0, 2);
    chk("b2b_cnt", CNT, 8'd3);

    // Underflow: EMPTY low but no data comes back
    lie = 1'b1;
    cyc();
    lie = 1'b0;
    repeat (8) cyc();
    chk("uf_err", ERR, 1'b1);
    chk("uf_cnt", CNT, 8'd3);
    fifo.push_back(16'h3C5A);
    drain(200);
    chk("uf_err_sticky", ERR, 1'b1);
    chk("uf_next_cnt", CNT, 8'd4);

    // EN gating
    EN = 1'b0;
    r0 = rd_pulses;
    fifo.push_back(16'h1234);
    fifo.push_back(16'h5678);
    repeat (20) cyc();
    chk("en0_rd", rd_pulses - r0, 0);
    EN = 1'b1;
    wait_rd(10);
    repeat (12) cyc();
    EN = 1'b0;
    repeat (100) cyc();
    chk("en_drop_rd", rd_pulses - r0, 1);
    chk("en_drop_cnt", CNT, 8'd5);
    chk("en_drop_busy", BUSY, 1'b0);

    // Reset during data bit 7 of 16'h5678
    EN = 1'b1;
    wait_rd(10);
    repeat (35) cyc();
    chk("pre_rst_busy", BUSY, 1'b1);
    do_reset();
    fifo.push_back(16'h9ABC);
    drain(200);
    chk("post_rst_cnt", CNT, 8'd1);

    // Counter wrap after 256 frames
    do_reset();
    d0 = done_pulses;
    for (int i = 0; i < 256; i++) fifo.push_back(16'(i * 16'd257 + 16'd1));
    drain(30000);
    chk("wrap_cnt", CNT, 8'd0);
    chk("wrap_done", done_pulses - d0, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter DIV, default 4, SHALL set clock cycles per serial bit (legal range 1..255).
REQ-002 CLK  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 EN  input  1  SHALL allow a new FIFO read and frame when high.
REQ-005 EMPTY  input  1  SHALL be the FIFO empty flag.
REQ-006 VALID  input  1  SHALL be the FIFO read-data-valid flag, high in the cycle after an accepted RD.
REQ-007 DIN  input  16  SHALL be the FIFO read data (DOUT), sampled only when VALID=1.
REQ-008 RD  output  1  SHALL be the FIFO read strobe.
REQ-009 SOUT  output  1  SHALL be the serial line, idle high.
REQ-010 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-011 DONE  output  1  SHALL pulse for one cycle on the last cycle of each stop bit.
REQ-012 ERR  output  1  SHALL be a sticky flag for a read that returned no data.
REQ-013 CNT  output  8  SHALL count completed frames.

Function
REQ-014 States SHALL be IDLE, REQ, WAIT, START, DATA and STOP.
REQ-015 IDLE -> REQ SHALL occur when EN=1 and EMPTY=0; otherwise the block SHALL hold in IDLE.
REQ-016 RD SHALL be 1 only in REQ, for exactly one cycle, registered, with no glitches.
REQ-017 REQ -> WAIT SHALL be unconditional.
REQ-018 In WAIT with VALID=1: DIN SHALL load the 16-bit shift register and the next state SHALL be START.
REQ-019 In WAIT with VALID=0: ERR SHALL set to 1, the next state SHALL be IDLE, and no frame SHALL be sent.
REQ-020 START SHALL drive SOUT=0 for DIV cycles, then go to DATA.
REQ-021 DATA SHALL send 16 bits, LSB first, each held DIV cycles; a 4-bit bit index SHALL advance after each bit; after bit 15 the next state SHALL be STOP.
REQ-022 STOP SHALL drive SOUT=1 for DIV cycles; on the last cycle DONE=1 and CNT SHALL increment, and the next state SHALL be IDLE.
REQ-023 CNT SHALL wrap 255 -> 0 with no flag.
REQ-024 SOUT SHALL be 1 in IDLE, REQ and WAIT; SOUT SHALL come from a register.
REQ-025 Back-to-back frames: the gap between a stop bit and the next start bit SHALL be exactly 3 cycles of SOUT=1 (IDLE, REQ, WAIT).
REQ-026 EN falling mid-frame SHALL NOT abort the frame; the frame SHALL complete and the block SHALL then stay in IDLE.
REQ-027 The block SHALL ignore EMPTY and VALID outside IDLE and WAIT respectively.
REQ-028 The baud counter SHALL count 0..DIV-1 and reload on each bit boundary; with DIV=1 each bit SHALL last one cycle.
REQ-029 Frame length SHALL be 18*DIV cycles, from the first START cycle to the DONE cycle inclusive.

Reset
REQ-030 RST=0 SHALL force, immediately and asynchronously: state=IDLE, RD=0, SOUT=1, BUSY=0, DONE=0, ERR=0, CNT=0, shift register=0, bit index=0, baud counter=0.
REQ-031 Reset mid-frame SHALL abandon the frame; SOUT SHALL return to 1 with no stop bit, and the already-read word SHALL be lost.
REQ-032 After RST rises, the first REQ SHALL occur no earlier than the first rising edge with EN=1 and EMPTY=0.

Verification (DIV=4)
REQ-033 Single word: EMPTY=0 for 1 cycle, VALID=1 with DIN=16'hA5C3 in WAIT -> RD high 1 cycle; SOUT = 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; DONE once; CNT=1.
REQ-034 Back-to-back: words 16'h0001 and 16'h8000 queued -> two frames separated by exactly 3 high cycles; CNT=2; RD pulses exactly 2.
REQ-035 Underflow: EMPTY=0, VALID=0 in WAIT -> ERR=1 and stays 1; SOUT stays 1; CNT unchanged; the next valid word is still sent normally.
REQ-036 EN gating: EN=0 with EMPTY=0 -> RD never asserts; EN dropped during DATA -> frame completes and no further RD occurs.
REQ-037 Reset mid-DATA: RST low for 1 cycle during bit 7 -> outputs take REQ-030 values immediately, without waiting for a clock edge; the next word is sent correctly.
REQ-038 Wrap: 256 frames -> CNT=0, DONE count=256.
